// File: rtl/axi_read_arbiter.sv
// Shared AXI read channel for icache refill, dcache refill and uncached loads:
// fixed-priority grant, one burst in flight, beats assembled into a line/word.
module axi_read_arbiter #(
  parameter logic [3:0] ARID_VAL = 4'd0
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         icache_req,
  input  logic         icache_uncache,
  input  logic [31:0]  icache_addr,
  output logic         icache_addr_ready,
  output logic         icache_data_ready,
  output logic [127:0] icache_rdata,
  input  logic         dcache_rd_req,
  input  logic [31:0]  dcache_rd_addr,
  output logic         dcache_rd_rdy,
  output logic         dcache_ret_valid,
  output logic [127:0] dcache_ret_data,
  input  logic         uncache_rd_req,
  input  logic [2:0]   uncache_rd_size,
  input  logic [31:0]  uncache_rd_addr,
  output logic         uncache_rd_rdy,
  output logic         uncache_ret_valid,
  output logic [31:0]  uncache_ret_data,
  output logic [3:0]   arid,
  output logic [31:0]  araddr,
  output logic [7:0]   arlen,
  output logic [2:0]   arsize,
  output logic [1:0]   arburst,
  output logic         arvalid,
  input  logic         arready,
  input  logic [3:0]   rid,
  input  logic [31:0]  rdata,
  input  logic [1:0]   rresp,
  input  logic         rlast,
  input  logic         rvalid,
  output logic         rready,
  output logic [1:0]   o_dbg_state
);

  localparam int LINE_BEATS = 4;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ADDR = 2'd1, S_DATA = 2'd2, S_RET = 2'd3} state_t;
  typedef enum logic [1:0] {SRC_DC = 2'd0, SRC_UNC = 2'd1, SRC_IC = 2'd2} src_t;

  // Valid/ready: a transfer happens in a cycle where both valid (or req) and
  // ready (or rdy) are high; the initiator holds its payload stable until then.

  state_t             r_state;
  state_t             w_next;
  src_t               r_src;
  logic               r_ic_unc;
  logic [31:0]        r_araddr;
  logic [7:0]         r_arlen;
  logic [2:0]         r_arsize;
  logic [1:0]         r_cnt;
  logic [3:0][31:0]   r_buf;

  logic w_idle, w_dc_go, w_unc_go, w_ic_go, w_beat_ok;
  logic w_unused;

  // Grant is gated by resetn so no rdy is offered while reset is asserted.
  assign w_idle    = (r_state == S_IDLE) && resetn;
  assign w_dc_go   = w_idle && dcache_rd_req;
  assign w_unc_go  = w_idle && !dcache_rd_req && uncache_rd_req;
  assign w_ic_go   = w_idle && !dcache_rd_req && !uncache_rd_req && icache_req;
  assign w_beat_ok = (r_state == S_DATA) && rvalid && (rid == ARID_VAL);
  assign w_unused  = ^{rresp, dcache_rd_addr[3:0]};

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_dc_go || w_unc_go || w_ic_go) w_next = S_ADDR;
      S_ADDR: if (arready) w_next = S_DATA;
      S_DATA: if (w_beat_ok && rlast) w_next = S_RET;
      S_RET:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_src    <= SRC_DC;
      r_ic_unc <= 1'b0;
      r_araddr <= '0;
      r_arlen  <= '0;
      r_arsize <= '0;
      r_cnt    <= '0;
      r_buf    <= '0;
    end else begin
      if (w_dc_go) begin
        r_src    <= SRC_DC;
        r_ic_unc <= 1'b0;
        r_araddr <= {dcache_rd_addr[31:4], 4'b0};
        r_arlen  <= 8'(LINE_BEATS - 1);
        r_arsize <= 3'd2;
      end else if (w_unc_go) begin
        r_src    <= SRC_UNC;
        r_ic_unc <= 1'b0;
        r_araddr <= uncache_rd_addr;
        r_arlen  <= 8'd0;
        r_arsize <= uncache_rd_size;
      end else if (w_ic_go) begin
        r_src    <= SRC_IC;
        r_ic_unc <= icache_uncache;
        r_araddr <= icache_uncache ? icache_addr : {icache_addr[31:4], 4'b0};
        r_arlen  <= icache_uncache ? 8'd0 : 8'(LINE_BEATS - 1);
        r_arsize <= 3'd2;
      end
      if ((r_state == S_ADDR) && arready) r_cnt <= '0;
      // Beats beyond the fourth wrap the counter and overwrite from word 0.
      if (w_beat_ok) begin
        r_buf[r_cnt] <= rdata;
        r_cnt        <= r_cnt + 2'd1;
      end
    end
  end

  assign dcache_rd_rdy     = w_dc_go;
  assign uncache_rd_rdy    = w_unc_go;
  assign icache_addr_ready = w_ic_go;

  assign arid    = ARID_VAL;
  assign arburst = 2'b01;
  assign arvalid = (r_state == S_ADDR);
  assign araddr  = r_araddr;
  assign arlen   = r_arlen;
  assign arsize  = r_arsize;
  assign rready  = (r_state == S_DATA);

  assign dcache_ret_valid  = (r_state == S_RET) && (r_src == SRC_DC);
  assign uncache_ret_valid = (r_state == S_RET) && (r_src == SRC_UNC);
  assign icache_data_ready = (r_state == S_RET) && (r_src == SRC_IC);
  assign dcache_ret_data   = r_buf;
  assign uncache_ret_data  = r_buf[0];
  assign icache_rdata      = r_ic_unc ? {4{r_buf[0]}} : r_buf;

  assign o_dbg_state = r_state;

endmodule

// File: doc/axi_read_arbiter.md
# axi_read_arbiter

Single-outstanding AXI read-channel arbiter and burst sequencer sharing the AR/R channels between the instruction-cache refill port, the data-cache refill port and the uncached load port. It accepts one request at a time by fixed priority, issues one AXI read burst, assembles the returned beats into a cache line or single word, and returns it to the winning requester. It sits between the cache/uncache request ports and the top-level AXI master pins, replacing the read half of the CPU-to-AXI bridge.

## Interface
- ARID_VAL, 4'd0: constant driven on arid; also the only rid value accepted.
- LINE_BEATS, 4: beats per cache-line refill. Fixed at 4, giving a 128-bit line.
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- icache_req  in  1  instruction fetch request.
- icache_uncache  in  1  fetch is uncached; single word.
- icache_addr  in  32  fetch address.
- icache_addr_ready  out  1  fetch request accepted.
- icache_data_ready  out  1  one-cycle pulse: icache_rdata valid.
- icache_rdata  out  128  line, or uncached word replicated to all 4 lanes.
- dcache_rd_req  in  1  data line refill request.
- dcache_rd_addr  in  32  refill address.
- dcache_rd_rdy  out  1  refill accepted.
- dcache_ret_valid  out  1  one-cycle pulse: dcache_ret_data valid.
- dcache_ret_data  out  128  refilled line; word k in bits [32k+31:32k].
- uncache_rd_req  in  1  uncached load request.
- uncache_rd_size  in  3  AXI size encoding: 0 = byte, 1 = half, 2 = word.
- uncache_rd_addr  in  32  load address, passed unmodified.
- uncache_rd_rdy  out  1  load accepted.
- uncache_ret_valid  out  1  one-cycle pulse: uncache_ret_data valid.
- uncache_ret_data  out  32  raw rdata beat.
- arid  out  4  ARID_VAL.
- araddr  out  32  burst address.
- arlen  out  8  beats minus 1.
- arsize  out  3  beat size.
- arburst  out  2  2'b01 (INCR).
- arvalid  out  1  address valid.
- arready  in  1  address accepted.
- rid  in  4  read ID.
- rdata  in  32  beat data.
- rresp  in  2  response code; ignored.
- rlast  in  1  last beat.
- rvalid  in  1  beat valid.
- rready  out  1  beat accepted.

## Operation
- FSM states: IDLE → ADDR → DATA → RET → IDLE.
- **IDLE**
  - Grant one requester by fixed priority: dcache > uncache > icache.
  - The winner's rdy is driven combinationally high only in IDLE and only for the winner. A handshake is req && rdy in the same cycle.
  - On handshake, latch the requester ID, araddr, arlen and arsize, then go to ADDR.
  - Requesters hold req and address until rdy. Losing requests are not accepted and not affected.
- **Burst parameters**
  - Cached line (dcache, or icache with icache_uncache=0): araddr = {addr[31:4], 4'b0}, arlen = 3, arsize = 2.
  - Uncached icache: araddr = addr, arlen = 0, arsize = 2.
  - Uncache port: araddr = addr, arlen = 0, arsize = uncache_rd_size.
- **ADDR**: arvalid=1, held with stable fields until arready. On arvalid && arready, go to DATA and clear the 2-bit beat counter.
- **DATA**
  - rready=1.
  - A beat with rvalid && rid==ARID_VAL writes rdata into buffer word[counter], then the counter increments (wraps at 4).
  - Beats with any other rid are consumed and discarded.
  - rlast on an accepted beat goes to RET, regardless of the counter value.
  - Short bursts leave the remaining buffer words at their stale values. More than 4 beats wrap and overwrite word 0.
- **RET**: exactly one cycle. The latched requester's valid pulses with buffer data, then return to IDLE.
  - icache uncached: word 0 is replicated to all 4 lanes.
  - uncache: word 0 is returned.
- rresp is ignored; there is no error path.
- Only one transaction is outstanding; new requests are accepted only in IDLE.
- **Reset**: asynchronous resetn=0 forces IDLE from any state. Counter, buffer and latched fields clear to 0, abandoning any in-flight burst. All outputs are 0 during and after reset except arburst=2'b01 and arid=ARID_VAL.

## Timing
- Cycle 0: handshake in IDLE.
- Cycle 1: arvalid=1.
- arready in cycle 1 → DATA from cycle 2. Best-case beats in cycles 2–5, with rlast in 5.
- Valid pulse in cycle 6, IDLE in cycle 7. Earliest next accept is cycle 7.
- Uncached best case: accept 0, AR 1, beat 2, valid 3.
- Each arready or rvalid stall adds exactly one cycle.
- All data and valid outputs are registered from state/buffer. Only the rdy signals are combinational from req inputs.

## Test plan
- Cached dcache refill at 0x1FC0_0024, arready immediate, beats 0xA0..0xA3 back-to-back → araddr=0x1FC0_0020, arlen=3, arsize=2, arburst=1; dcache_ret_valid pulses in cycle 6 with ret_data=0x000000A3_000000A2_000000A1_000000A0.
- All three requests asserted in the same cycle → dcache, uncache and icache are accepted in that order. Each accept is one cycle after the previous RET. No rdy overlaps.
- Uncache byte load at 0xBFAF_8003, size 0, rdata 0x5500_0000 → araddr=0xBFAF_8003, arlen=0, arsize=0; uncache_ret_valid with data 0x5500_0000.
- Icache uncached fetch with arready delayed 3 cycles and a 2-cycle rvalid gap → arvalid held 4 cycles with fields stable; icache_rdata = the word ×4; icache_data_ready pulses exactly once.
- Beat with rid=5 during a DATA burst → discarded; buffer and counter unchanged.
- resetn low in mid-DATA after 2 beats → all outputs 0 immediately. After release, a new icache request is accepted and its line contains no stale words.
